rcv_block_fifo: RTL and testbench
=================================

Name: rcv_block_fifo

Overview:
- Parametrised successor to the fixed 128-bit receive FIFO in the AHB I/O path.
- Accepts bus-width words from the AHB slave, packs them into cipher-width blocks, and buffers DEPTH complete blocks for the AES core.
- Adds frame tracking with an end-of-frame marker, a sticky framing/overflow error with a recovery handshake, and an occupancy count.
- Sits between ahb_slave (word writes) and the encrypt/decrypt datapath (block dequeue).

Parameters:
WORD_W, 32, width of one AHB data word.
BLOCK_W, 128, cipher block width; must be an integer multiple of WORD_W.
DEPTH, 4, number of complete blocks stored; power of 2, at least 2.
AFULL_LVL, 3, almost-full threshold in blocks; only used with the optional feature.

Ports:
HCLK  in  1  system clock. One clock; reset is asynchronous and active-high.
HRESET  in  1  asynchronous active-high reset.
wr_word_en  in  1  one-cycle strobe: wr_word is valid this cycle.
wr_word  in  WORD_W  data word from the AHB slave.
wr_last  in  1  qualifies wr_word_en; marks the final word of a frame.
fix_error  in  1  clears framing_error and discards the partial block.
blk_deq  in  1  pop the head block.
blk_out  out  BLOCK_W  head block, first-word-fall-through.
full  out  1  DEPTH blocks are stored.
empty  out  1  no complete block is stored.
count  out  $clog2(DEPTH+1)  number of stored complete blocks.
word_idx  out  $clog2(BLOCK_W/WORD_W)  next word slot in the packer.
framing_error  out  1  sticky error flag.
almost_full  out  1  present only with RCV_BLK_AFULL_EN.

Behaviour:
- Definitions: WPB = BLOCK_W/WORD_W.
- Reset values: count=0, empty=1, full=0, framing_error=0, word_idx=0, blk_out=0, almost_full=0. Read and write pointers, packer register and state all return to reset values immediately on HRESET, including mid-frame; any partial block is lost.
- State machine:
  - IDLE: word_idx==0. Accepted word goes to FILL, or commits immediately if WPB==1.
  - FILL: 0<word_idx<WPB.
  - ERR: framing_error=1.
- Packing order: the word at slot k is written to bits [BLOCK_W-1-k*WORD_W -: WORD_W], so the first word is most significant.
- Word acceptance (not in ERR): word_idx increments modulo WPB.
  - At slot WPB-1 the packed block commits to storage at that edge.
  - The block is visible on blk_out and empty falls in the following cycle.
- Frame end:
  - wr_last on slot WPB-1 commits the block and returns to IDLE.
  - wr_last on any other slot sets framing_error and enters ERR; the partial block is discarded and not committed.
- Overflow: a commit while full=1 with no blk_deq in the same cycle drops the block, sets framing_error and enters ERR. Storage contents are unchanged.
- ERR:
  - All wr_word_en are ignored.
  - blk_deq still operates, so stored blocks stay drainable.
  - fix_error: next edge clears framing_error and word_idx, then IDLE.
  - fix_error outside ERR discards any partial block and sets word_idx=0.
- Dequeue:
  - blk_deq with empty=0 advances the read pointer; the next block appears the following cycle.
  - blk_deq while empty is ignored with no underflow.
- Simultaneous commit and dequeue:
  - Both happen; count is unchanged.
  - Legal when full: no overflow, and full stays 1.
  - When count==1, blk_out shows the newly committed block next cycle and empty stays 0.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- full and empty are registered, derived from count.

Optional Feature:
- Macro RCV_BLK_AFULL_EN.
- Defined: port almost_full = (count >= AFULL_LVL), registered together with count. Used by ahb_slave to insert HREADY wait states.
- Undefined: the port and its logic are absent and AFULL_LVL is unused.

Decomposition:
- Shared package aes_io_pkg:
  - WORD_W and BLOCK_W constants.
  - typedef logic [BLOCK_W-1:0] block_t.
  - rx_state_t enum {IDLE, FILL, ERR}.
- One sub-module, blk_packer: word_idx counter, packing register, and commit/error pulse generation.
- The top level holds the block ring storage, pointers, count and flags.

Test Plan:
- Reset, then write words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with wr_last on the 4th. The next cycle must show empty=0, count=1, blk_out=0x00112233_44556677_8899AABB_CCDDEEFF. Then blk_deq gives empty=1.
- Write 5 full blocks without dequeue (DEPTH=4). After the 4th, full=1. The 5th commit sets framing_error=1 and count stays 4. Four dequeues return blocks 1-4 in order.
- Write 2 words then wr_last: framing_error=1 and count=0. Further writes are ignored. fix_error, then a clean 4-word block gives count=1 and correct data.
- With full=1, assert the 4th-word commit and blk_deq in the same cycle: no error, count=4, and the head advances to block 2.
- Assert HRESET mid-frame after 2 words: word_idx=0, count=0, empty=1. A subsequent 4-word block packs from slot 0.
- With RCV_BLK_AFULL_EN defined and AFULL_LVL=3: almost_full rises with count=3 and falls after a dequeue brings count to 2.

Source files
------------

// File: rtl/aes_io_pkg.sv
// Shared types and constants for the AES I/O path: bus/cipher widths, block type,
// and the receive packer state encoding.
package aes_io_pkg;

   localparam int AES_WORD_W  = 32;
   localparam int AES_BLOCK_W = 128;

   typedef logic [AES_BLOCK_W-1:0] block_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      ERR  = 2'd2
   } rx_state_t;

   // Index width that stays legal when a block holds a single word.
   function automatic int idx_width(input int wpb);
      return (wpb > 1) ? $clog2(wpb) : 1;
   endfunction

endpackage

// File: rtl/blk_packer.sv
// Packs bus words into cipher blocks (first word most significant) and produces
// a one-cycle commit strobe, the next-slot index and the sticky framing error.
module blk_packer
   import aes_io_pkg::*;
#(
   parameter  int WORD_W  = AES_WORD_W,
   parameter  int BLOCK_W = AES_BLOCK_W,
   localparam int WPB     = BLOCK_W / WORD_W,
   localparam int IDX_W   = idx_width(WPB)
)(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_wr_en,
   input  logic [WORD_W-1:0]  i_wr_word,
   input  logic               i_wr_last,
   input  logic               i_fix_error,
   input  logic               i_no_room,
   output logic               o_commit,
   output logic [BLOCK_W-1:0] o_block,
   output logic [IDX_W-1:0]   o_word_idx,
   output logic               o_error
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPB - 1);

   rx_state_t          r_state;
   rx_state_t          w_state_nxt;
   logic [IDX_W-1:0]   r_idx;
   logic [IDX_W-1:0]   w_idx_nxt;
   logic [BLOCK_W-1:0] r_pack;
   logic [BLOCK_W-1:0] w_pack;
   logic               w_accept;
   logic               w_at_last;

   assign w_accept  = i_wr_en && (r_state != ERR) && !i_fix_error;
   assign w_at_last = (r_idx == LAST_IDX);

   // Current word merged into its slot; at the last slot this is the committed block.
   always_comb begin
      w_pack = r_pack;
      for (int k = 0; k < WPB; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_pack[BLOCK_W-1-k*WORD_W -: WORD_W] = i_wr_word;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      o_commit    = 1'b0;
      case (r_state)
         ERR: begin
            if (i_fix_error) begin
               w_state_nxt = IDLE;
               w_idx_nxt   = '0;
            end
         end
         default: begin
            if (i_fix_error) begin
               w_state_nxt = IDLE;
               w_idx_nxt   = '0;
            end else if (w_accept) begin
               if (w_at_last) begin
                  w_idx_nxt = '0;
                  if (i_no_room) begin
                     w_state_nxt = ERR;
                  end else begin
                     o_commit    = 1'b1;
                     w_state_nxt = IDLE;
                  end
               end else if (i_wr_last) begin
                  w_state_nxt = ERR;
                  w_idx_nxt   = '0;
               end else begin
                  w_state_nxt = FILL;
                  w_idx_nxt   = r_idx + IDX_W'(1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_pack  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         if (w_accept) begin
            r_pack <= w_pack;
         end
      end
   end

   assign o_block    = w_pack;
   assign o_word_idx = r_idx;
   assign o_error    = (r_state == ERR);

endmodule

// File: rtl/rcv_block_fifo.sv
// Receive block FIFO: word packer feeding a DEPTH-entry first-word-fall-through block ring.
// Optional almost_full output is built when RCV_BLK_AFULL_EN is defined.
module rcv_block_fifo
   import aes_io_pkg::*;
#(
   parameter  int WORD_W    = AES_WORD_W,
   parameter  int BLOCK_W   = AES_BLOCK_W,
   parameter  int DEPTH     = 4,
   parameter  int AFULL_LVL = 3,
   localparam int IDX_W     = idx_width(BLOCK_W / WORD_W),
   localparam int CNT_W     = $clog2(DEPTH + 1)
)(
   input  logic               HCLK,
   input  logic               HRESET,
   input  logic               wr_word_en,
   input  logic [WORD_W-1:0]  wr_word,
   input  logic               wr_last,
   input  logic               fix_error,
   input  logic               blk_deq,
   output logic [BLOCK_W-1:0] blk_out,
   output logic               full,
   output logic               empty,
   output logic [CNT_W-1:0]   count,
   output logic [IDX_W-1:0]   word_idx,
   output logic               framing_error
`ifdef RCV_BLK_AFULL_EN
   ,output logic              almost_full
`endif
);

   localparam int               PTR_W   = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [BLOCK_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wptr;
   logic [PTR_W-1:0]   r_rptr;
   logic [CNT_W-1:0]   r_count;
   logic [CNT_W-1:0]   w_count_nxt;
   logic               r_full;
   logic               r_empty;
   logic               w_commit;
   logic               w_deq;
   logic               w_no_room;
   logic [BLOCK_W-1:0] w_block;

   // A dequeue in the same cycle frees the slot, so a full FIFO still accepts the commit.
   assign w_deq     = blk_deq && !r_empty;
   assign w_no_room = r_full && !blk_deq;

   blk_packer #(
      .WORD_W  (WORD_W),
      .BLOCK_W (BLOCK_W)
   ) u_packer (
      .i_clk       (HCLK),
      .i_rst       (HRESET),
      .i_wr_en     (wr_word_en),
      .i_wr_word   (wr_word),
      .i_wr_last   (wr_last),
      .i_fix_error (fix_error),
      .i_no_room   (w_no_room),
      .o_commit    (w_commit),
      .o_block     (w_block),
      .o_word_idx  (word_idx),
      .o_error     (framing_error)
   );

   always_comb begin
      w_count_nxt = r_count;
      case ({w_commit, w_deq})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (w_commit) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_deq) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == DEPTH_C);
         r_empty <= (w_count_nxt == '0);
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_commit) begin
         r_mem[r_wptr] <= w_block;
      end
   end

`ifdef RCV_BLK_AFULL_EN
   localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_LVL);
   logic r_afull;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_afull <= 1'b0;
      end else begin
         r_afull <= (w_count_nxt >= AFULL_C);
      end
   end

   assign almost_full = r_afull;
`else
   logic w_unused_afull;
   assign w_unused_afull = ^AFULL_LVL;
`endif

   assign blk_out = r_mem[r_rptr];
   assign full    = r_full;
   assign empty   = r_empty;
   assign count   = r_count;

endmodule

// File: tb/tb_rcv_block_fifo.sv
// Directed self-checking bench for rcv_block_fifo (default DEPTH=4, 32-bit words, 128-bit blocks).
module tb_rcv_block_fifo;

   logic         HCLK = 1'b0;
   logic         HRESET = 1'b1;
   logic         wr_word_en = 1'b0;
   logic [31:0]  wr_word = '0;
   logic         wr_last = 1'b0;
   logic         fix_error = 1'b0;
   logic         blk_deq = 1'b0;
   logic [127:0] blk_out;
   logic         full;
   logic         empty;
   logic [2:0]   count;
   logic [1:0]   word_idx;
   logic         framing_error;
`ifdef RCV_BLK_AFULL_EN
   logic         almost_full;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   rcv_block_fifo dut (
      .HCLK          (HCLK),
      .HRESET        (HRESET),
      .wr_word_en    (wr_word_en),
      .wr_word       (wr_word),
      .wr_last       (wr_last),
      .fix_error     (fix_error),
      .blk_deq       (blk_deq),
      .blk_out       (blk_out),
      .full          (full),
      .empty         (empty),
      .count         (count),
      .word_idx      (word_idx),
      .framing_error (framing_error)
`ifdef RCV_BLK_AFULL_EN
      ,.almost_full  (almost_full)
`endif
   );

   always #5 HCLK = ~HCLK;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "bench did not finish");
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] wd(input int n, input int k);
      return {16'hB10C, 8'(n), 8'(k)};
   endfunction

   function automatic logic [127:0] mk(input int n);
      return {wd(n, 0), wd(n, 1), wd(n, 2), wd(n, 3)};
   endfunction

   task automatic wr(input logic [31:0] w, input logic last, input logic deq);
      wr_word_en = 1'b1;
      wr_word    = w;
      wr_last    = last;
      blk_deq    = deq;
      @(posedge HCLK); #1;
      wr_word_en = 1'b0;
      wr_last    = 1'b0;
      blk_deq    = 1'b0;
   endtask

   task automatic put_block(input int n, input logic deq_on_last);
      for (int k = 0; k < 4; k++) begin
         wr(wd(n, k), k == 3, (k == 3) && deq_on_last);
      end
   endtask

   task automatic deq();
      blk_deq = 1'b1;
      @(posedge HCLK); #1;
      blk_deq = 1'b0;
   endtask

   task automatic fix();
      fix_error = 1'b1;
      @(posedge HCLK); #1;
      fix_error = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge HCLK);
      #1 HRESET = 1'b0;

      chk("rst_count", 128'(count), 128'd0);
      chk("rst_empty", 128'(empty), 128'd1);
      chk("rst_full", 128'(full), 128'd0);
      chk("rst_err", 128'(framing_error), 128'd0);
      chk("rst_idx", 128'(word_idx), 128'd0);
      chk("rst_blk", blk_out, 128'd0);
`ifdef RCV_BLK_AFULL_EN
      chk("rst_afull", 128'(almost_full), 128'd0);
`endif

      // Single block, packing order
      wr(32'h00112233, 1'b0, 1'b0);
      chk("t1_idx1", 128'(word_idx), 128'd1);
      chk("t1_empty_fill", 128'(empty), 128'd1);
      wr(32'h44556677, 1'b0, 1'b0);
      wr(32'h8899AABB, 1'b0, 1'b0);
      wr(32'hCCDDEEFF, 1'b1, 1'b0);
      chk("t1_empty", 128'(empty), 128'd0);
      chk("t1_count", 128'(count), 128'd1);
      chk("t1_blk", blk_out, 128'h00112233_44556677_8899AABB_CCDDEEFF);
      chk("t1_idx0", 128'(word_idx), 128'd0);
      deq();
      chk("t1_deq_empty", 128'(empty), 128'd1);
      chk("t1_deq_count", 128'(count), 128'd0);

      // Fill to full, then overflow
      for (int n = 1; n <= 4; n++) put_block(n, 1'b0);
      chk("t2_full", 128'(full), 128'd1);
      chk("t2_count4", 128'(count), 128'd4);
      chk("t2_err_pre", 128'(framing_error), 128'd0);
      put_block(5, 1'b0);
      chk("t2_ovf_err", 128'(framing_error), 128'd1);
      chk("t2_ovf_count", 128'(count), 128'd4);
      chk("t2_ovf_full", 128'(full), 128'd1);
      for (int n = 1; n <= 4; n++) begin
         chk($sformatf("t2_head%0d", n), blk_out, mk(n));
         deq();
      end
      chk("t2_drained", 128'(empty), 128'd1);
      chk("t2_still_err", 128'(framing_error), 128'd1);
      put_block(99, 1'b0);
      chk("t2_err_ignore_cnt", 128'(count), 128'd0);
      chk("t2_err_ignore_idx", 128'(word_idx), 128'd0);
      deq();
      chk("t2_underflow_cnt", 128'(count), 128'd0);
      chk("t2_underflow_empty", 128'(empty), 128'd1);
      fix();
      chk("t2_fix_err", 128'(framing_error), 128'd0);

      // Short frame: wr_last on slot 1
      wr(wd(40, 0), 1'b0, 1'b0);
      wr(wd(40, 1), 1'b1, 1'b0);
      chk("t3_err", 128'(framing_error), 128'd1);
      chk("t3_count", 128'(count), 128'd0);
      put_block(41, 1'b0);
      chk("t3_ignored_cnt", 128'(count), 128'd0);
      chk("t3_ignored_empty", 128'(empty), 128'd1);
      fix();
      chk("t3_fix_err", 128'(framing_error), 128'd0);
      chk("t3_fix_idx", 128'(word_idx), 128'd0);
      put_block(6, 1'b0);
      chk("t3_count1", 128'(count), 128'd1);
      chk("t3_blk", blk_out, mk(6));
      deq();

      // Commit and dequeue together while full
      for (int n = 7; n <= 10; n++) put_block(n, 1'b0);
      chk("t4_full_pre", 128'(full), 128'd1);
      put_block(11, 1'b1);
      chk("t4_err", 128'(framing_error), 128'd0);
      chk("t4_count", 128'(count), 128'd4);
      chk("t4_full", 128'(full), 128'd1);
      for (int n = 8; n <= 11; n++) begin
         chk($sformatf("t4_head%0d", n), blk_out, mk(n));
         deq();
      end
      chk("t4_empty", 128'(empty), 128'd1);

      // Commit and dequeue together with one block stored
      put_block(12, 1'b0);
      put_block(13, 1'b1);
      chk("t5_count", 128'(count), 128'd1);
      chk("t5_empty", 128'(empty), 128'd0);
      chk("t5_blk", blk_out, mk(13));
      deq();

      // fix_error outside ERR discards the partial block
      wr(wd(50, 0), 1'b0, 1'b0);
      wr(wd(50, 1), 1'b0, 1'b0);
      chk("t6_idx2", 128'(word_idx), 128'd2);
      fix();
      chk("t6_idx0", 128'(word_idx), 128'd0);
      chk("t6_err", 128'(framing_error), 128'd0);
      put_block(14, 1'b0);
      chk("t6_blk", blk_out, mk(14));
      chk("t6_count", 128'(count), 128'd1);

      // Asynchronous reset mid-frame
      wr(wd(60, 0), 1'b0, 1'b0);
      wr(wd(60, 1), 1'b0, 1'b0);
      HRESET = 1'b1;
      #2;
      chk("t7_idx", 128'(word_idx), 128'd0);
      chk("t7_count", 128'(count), 128'd0);
      chk("t7_empty", 128'(empty), 128'd1);
      chk("t7_blk", blk_out, 128'd0);
      HRESET = 1'b0;
      @(posedge HCLK); #1;
      put_block(16, 1'b0);
      chk("t7_after_blk", blk_out, mk(16));
      chk("t7_after_cnt", 128'(count), 128'd1);
      deq();

`ifdef RCV_BLK_AFULL_EN
      put_block(20, 1'b0);
      put_block(21, 1'b0);
      chk("af_cnt2", 128'(almost_full), 128'd0);
      put_block(22, 1'b0);
      chk("af_cnt3", 128'(almost_full), 128'd1);
      deq();
      chk("af_back2_cnt", 128'(count), 128'd2);
      chk("af_back2", 128'(almost_full), 128'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
